// File: rtl/cnt_seq_ctrl_if.sv
// Command handshake between the test/control logic and the counter sequencer.
interface cnt_seq_ctrl_if #(
  parameter int P_BIT      = 4,
  parameter int P_WRAP_BIT = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [P_BIT-1:0]      cmd_load;
  logic [P_WRAP_BIT-1:0] cmd_wraps;

  modport master (output cmd_valid, cmd_load, cmd_wraps, input cmd_ready);
  modport slave  (input cmd_valid, cmd_load, cmd_wraps, output cmd_ready);
endinterface

// File: rtl/cnt_seq_ctrl.sv
// Load/run sequencer for the P_BIT up-counter: loads a start value, runs for N wraps, reports done.
// Optional watchdog on a carry-less RUN phase is enabled by defining CNT_SEQ_CTRL_TIMEOUT_EN.
module cnt_seq_ctrl #(
  parameter int P_BIT      = 4,
  parameter int P_WRAP_BIT = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  cnt_seq_ctrl_if.slave         cmd,
  input  logic                  abort,
  output logic                  enable,
  output logic                  wenable,
  output logic [P_BIT-1:0]      wcount,
  input  logic                  carry,
  input  logic [P_BIT-1:0]      count,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [P_WRAP_BIT-1:0] wrap_cnt,
  output logic [P_BIT-1:0]      last_count
`ifdef CNT_SEQ_CTRL_TIMEOUT_EN
  ,
  output logic                  timeout
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [P_WRAP_BIT-1:0] target_q, target_d;
  logic [P_BIT-1:0]      wcount_q, wcount_d;
  logic [P_WRAP_BIT-1:0] wrap_q, wrap_d;
  logic                  aborted_q, aborted_d;
  logic [P_BIT-1:0]      last_q, last_d;
  logic                  enable_q, wenable_q, busy_q, done_q;

`ifdef CNT_SEQ_CTRL_TIMEOUT_EN
  // Last watchdog value before the 2^(P_BIT+1)-th carry-less RUN cycle.
  localparam logic [P_BIT+1:0] WD_LAST = {2'b01, {P_BIT{1'b1}}};
  logic [P_BIT+1:0] wdog_q, wdog_d;
  logic             timeout_q, timeout_d;
`endif

  function automatic logic [P_WRAP_BIT-1:0] sat_inc(input logic [P_WRAP_BIT-1:0] v);
    return (v == {P_WRAP_BIT{1'b1}}) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    wcount_d  = wcount_q;
    wrap_d    = wrap_q;
    aborted_d = aborted_q;
`ifdef CNT_SEQ_CTRL_TIMEOUT_EN
    wdog_d    = wdog_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd.cmd_valid) begin
          target_d  = cmd.cmd_wraps;
          wcount_d  = cmd.cmd_load;
          wrap_d    = '0;
          aborted_d = 1'b0;
`ifdef CNT_SEQ_CTRL_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
`ifdef CNT_SEQ_CTRL_TIMEOUT_EN
        wdog_d = '0;
`endif
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else if (target_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (carry) wrap_d = sat_inc(wrap_q);
`ifdef CNT_SEQ_CTRL_TIMEOUT_EN
        wdog_d = carry ? '0 : wdog_q + 1'b1;
`endif
        // Abort has priority over the final carry, but that carry is still counted.
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else if (carry && (wrap_q == target_q - 1'b1)) begin
          state_d = S_DONE;
`ifdef CNT_SEQ_CTRL_TIMEOUT_EN
        end else if (!carry && (wdog_q == WD_LAST)) begin
          aborted_d = 1'b1;
          timeout_d = 1'b1;
          state_d   = S_DONE;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    last_d = (state_d == S_DONE) ? count : last_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      target_q  <= '0;
      wcount_q  <= '0;
      wrap_q    <= '0;
      aborted_q <= 1'b0;
      last_q    <= '0;
      enable_q  <= 1'b0;
      wenable_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef CNT_SEQ_CTRL_TIMEOUT_EN
      wdog_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      wcount_q  <= wcount_d;
      wrap_q    <= wrap_d;
      aborted_q <= aborted_d;
      last_q    <= last_d;
      enable_q  <= (state_d == S_RUN);
      wenable_q <= (state_d == S_LOAD);
      busy_q    <= (state_d == S_LOAD) || (state_d == S_RUN);
      done_q    <= (state_d == S_DONE);
`ifdef CNT_SEQ_CTRL_TIMEOUT_EN
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign cmd.cmd_ready = (state_q == S_IDLE);
  assign enable        = enable_q;
  assign wenable       = wenable_q;
  assign wcount        = wcount_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign aborted       = aborted_q;
  assign wrap_cnt      = wrap_q;
  assign last_count    = last_q;
`ifdef CNT_SEQ_CTRL_TIMEOUT_EN
  assign timeout       = timeout_q;
`endif

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Scoreboard bench for cnt_seq_ctrl: each command's outcome is predicted from its stimulus
// sequence and checked by an independent monitor when done pulses.
module tb_cnt_seq_ctrl;
  localparam int P_BIT      = 4;
  localparam int P_WRAP_BIT = 8;
  localparam int N          = 400;
  localparam int WD_CYC     = 1 << (P_BIT + 1);

  logic                  clk = 1'b0;
  logic                  resetn, abort, carry;
  logic [P_BIT-1:0]      count, wcount, last_count;
  logic                  enable, wenable, busy, done, aborted;
  logic [P_WRAP_BIT-1:0] wrap_cnt;
`ifdef CNT_SEQ_CTRL_TIMEOUT_EN
  logic                  timeout;
`endif

  cnt_seq_ctrl_if #(.P_BIT(P_BIT), .P_WRAP_BIT(P_WRAP_BIT)) cmd_if ();

  cnt_seq_ctrl #(.P_BIT(P_BIT), .P_WRAP_BIT(P_WRAP_BIT)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cmd        (cmd_if),
    .abort      (abort),
    .enable     (enable),
    .wenable    (wenable),
    .wcount     (wcount),
    .carry      (carry),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .wrap_cnt   (wrap_cnt),
    .last_count (last_count)
`ifdef CNT_SEQ_CTRL_TIMEOUT_EN
    ,
    .timeout    (timeout)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [P_BIT-1:0] load;
    int               wraps;
    int               run_cycles;
    bit               ab;
    logic [P_BIT-1:0] last;
    bit               tmo;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   accepts = 0;
  int   n_cmds  = 0;
  int   en_cnt  = 0;
  bit   last_ab = 0;
  bit   mon_en  = 0;

  task automatic chk(input string nm, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Issue one command starting at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
  task automatic run_cmd(input logic [P_BIT-1:0] ld, input int t, input bit abort_load,
                         input int pct, input int abort_k, input bit abort_same,
                         input int abort_cyc, input int rpct, input bit hold);
    bit               cs[N];
    bit               as_[N];
    logic [P_BIT-1:0] cn[N];
    logic [P_BIT-1:0] lc;
    exp_t             e;
    int               c, n, g;
    bit               stop;
    c = 0;
    for (int i = 0; i < N; i++) begin
      cs[i]  = ($urandom_range(99) < pct);
      as_[i] = ($urandom_range(99) < rpct);
      cn[i]  = P_BIT'($urandom);
      if (abort_k >= 0) begin
        if (abort_same) begin
          if (cs[i] && (c + 1 == abort_k)) as_[i] = 1'b1;
        end else if (c == abort_k) begin
          as_[i] = 1'b1;
          cs[i]  = 1'b0;
        end
      end
      if (i == abort_cyc) as_[i] = 1'b1;
      c += int'(cs[i]);
    end
    as_[N-1] = 1'b1;

    // Reference outcome: count carries until target reached, abort seen, or watchdog expiry.
    lc = P_BIT'($urandom);
    e.load = ld; e.wraps = 0; e.run_cycles = 0; e.ab = 0; e.tmo = 0; e.last = lc;
    if (!(abort_load || t == 0)) begin
      n = 0; g = 0; stop = 0;
      for (int i = 0; i < N && !stop; i++) begin
        if (as_[i]) begin
          n += int'(cs[i]); e.ab = 1; stop = 1;
        end else if (cs[i]) begin
          n++; g = 0;
          if (n == t) stop = 1;
`ifdef CNT_SEQ_CTRL_TIMEOUT_EN
        end else if (g == WD_CYC - 1) begin
          e.ab = 1; e.tmo = 1; stop = 1;
`endif
        end else begin
          g++;
        end
        if (stop) begin
          e.run_cycles = i + 1;
          e.last       = cn[i];
        end
      end
      e.wraps = n;
    end else begin
      e.ab = abort_load;
    end
    exp_q.push_back(e);
    n_cmds++;

    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_load  = ld;
    cmd_if.cmd_wraps = P_WRAP_BIT'(t);
    abort = 1'($urandom); carry = 1'($urandom); count = P_BIT'($urandom);
    @(negedge clk);
    cmd_if.cmd_valid = hold;
    cmd_if.cmd_load  = P_BIT'($urandom);
    cmd_if.cmd_wraps = P_WRAP_BIT'($urandom);
    abort = abort_load; carry = 1'($urandom); count = lc;
    @(negedge clk);
    for (int i = 0; i < e.run_cycles; i++) begin
      carry = cs[i]; abort = as_[i]; count = cn[i];
      @(negedge clk);
    end
    abort = 1'($urandom); carry = 1'($urandom); count = P_BIT'($urandom);
    @(negedge clk);
    abort = 1'b0; carry = 1'b0;
  endtask

  task automatic reset_mid_run();
    exp_t e;
    e.load = 4'h9; e.wraps = 0; e.run_cycles = 0; e.ab = 0; e.last = '0; e.tmo = 0;
    exp_q.push_back(e);
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_load = 4'h9; cmd_if.cmd_wraps = 8'd5;
    abort = 1'b0; carry = 1'b0;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      carry = (i % 2 == 0);
      @(negedge clk);
    end
    chk("pre_reset_wrap_cnt", wrap_cnt, 2);
    chk("pre_reset_busy", busy, 1);
    resetn = 1'b0; carry = 1'b1; abort = 1'b1;
    @(negedge clk);
    e = exp_q.pop_front();
    @(negedge clk);
    resetn = 1'b1; carry = 1'b0; abort = 1'b0;
    chk("rst_cmd_ready", cmd_if.cmd_ready, 1);
    chk("rst_enable", enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wrap_cnt", wrap_cnt, 0);
    chk("rst_wcount", wcount, 0);
    chk("rst_wenable", wenable, 0);
    for (int i = 0; i < 3; i++) begin
      chk("rst_no_done", done, 0);
      @(negedge clk);
    end
  endtask

  // Monitor: checks every done pulse against the scoreboard and watches the handshake.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (!resetn) begin
        last_ab = 1'b0;
        en_cnt  = 0;
      end else begin
        chk("ready_decode", cmd_if.cmd_ready, int'(!(busy || done)));
        if (busy) chk("en_wen_excl", int'(enable & wenable), 0);
        if (wenable) begin
          accepts++;
          en_cnt = 0;
          chk("q_depth_at_load", exp_q.size(), 1);
          if (exp_q.size() > 0) chk("wcount_at_load", wcount, exp_q[0].load);
          chk("aborted_cleared", aborted, 0);
          chk("load_enable_low", enable, 0);
        end
        if (enable) begin
          en_cnt++;
          chk("run_busy", busy, 1);
        end
        if (done) begin
          chk("q_depth_at_done", exp_q.size(), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("done_wrap_cnt", wrap_cnt, e.wraps);
            chk("done_aborted", aborted, e.ab);
            chk("done_last_count", last_count, e.last);
            chk("done_run_cycles", en_cnt, e.run_cycles);
            chk("done_wcount", wcount, e.load);
`ifdef CNT_SEQ_CTRL_TIMEOUT_EN
            chk("done_timeout", timeout, e.tmo);
`endif
            last_ab = e.ab;
          end
        end
        if (cmd_if.cmd_ready) chk("aborted_held", aborted, last_ab);
      end
    end
  end

  initial begin
    resetn = 1'b0; abort = 1'b0; carry = 1'b0; count = '0;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_load = '0; cmd_if.cmd_wraps = '0;
    repeat (3) @(negedge clk);
    chk("init_cmd_ready", cmd_if.cmd_ready, 1);
    chk("init_busy", busy, 0);
    chk("init_done", done, 0);
    chk("init_enable", enable, 0);
    chk("init_wrap_cnt", wrap_cnt, 0);
    chk("init_last_count", last_count, 0);
    resetn = 1'b1;
    mon_en = 1'b1;

    run_cmd(4'hC, 2, 0, 50, -1, 0, -1, 0, 0);    // basic run
    run_cmd(4'h3, 0, 0, 50, -1, 0, -1, 0, 0);    // zero target
    run_cmd(4'h5, 10, 0, 40, 3, 0, -1, 0, 0);    // abort after 3rd carry
    run_cmd(4'h6, 3, 0, 60, 3, 1, -1, 0, 0);     // abort on the final carry
    run_cmd(4'h7, 4, 1, 50, -1, 0, -1, 0, 0);    // abort during LOAD
    run_cmd(4'h1, 1, 0, 30, -1, 0, -1, 0, 1);    // valid held high across two commands
    run_cmd(4'h2, 1, 0, 30, -1, 0, -1, 0, 1);
    run_cmd(4'hF, 255, 0, 100, -1, 0, -1, 0, 0); // maximum target
    run_cmd(4'h4, 1, 0, 0, -1, 0, 100, 0, 0);    // no carry: watchdog or abort ends it
    cmd_if.cmd_valid = 1'b0;
    reset_mid_run();
    for (int k = 0; k < 40; k++)
      run_cmd(P_BIT'($urandom), int'($urandom_range(8)), ($urandom_range(9) == 0),
              int'($urandom_range(90, 20)), -1, 0, -1, 3, 1'($urandom));
    cmd_if.cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    chk("accept_count", accepts, n_cmds + 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
